lsu_unit: RTL and testbench

LSU_UNIT -- requirements
Module: lsu_unit

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_align.sv | 28 ++
 rtl/lsu_unit.sv | 103 ++++++++++
 tb/tb_lsu_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM states, RV32I load/store width codes and request legality check
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;
  function automatic logic illegal(input logic ld, input logic st, input logic [2:0] f3, input logic [1:0] a);
    return (ld && st) || (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) || (st && f3 > F3_SW) ||
           (f3[1:0] == 2'd2 && a != 2'd0) || (f3[1:0] == 2'd1 && a[0]);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load byte/halfword extraction with extension, store byte enables and lane replication
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[8*addr_lo +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
                funct3 == F3_LBU ? {24'd0, b} :
                funct3 == F3_LH  ? {{16{h[15]}}, h} :
                funct3 == F3_LHU ? {16'd0, h} : rdata;
    // enables follow access width only, so loads also get byte-accurate enables
    be    = funct3[1:0] == F3_SB[1:0] ? 4'b0001 << addr_lo :
            funct3[1:0] == F3_SH[1:0] ? 4'b0011 << {addr_lo[1], 1'b0} : 4'b1111;
    wdata = funct3[1:0] == F3_SB[1:0] ? {4{store_data[7:0]}} :
            funct3[1:0] == F3_SH[1:0] ? {2{store_data[15:0]}} : store_data;
  end
endmodule

// File: rtl/lsu_unit.sv
// lsu_unit: single-outstanding RV32I load/store unit with stall, alignment checks and response timeout
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_addr_i,
  output logic        stall_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [4:0]  rd_addr_o,
  output logic        wr_en_o,
  output logic [31:0] wr_data_o,
  output logic        err_o
);
  state_t      state, state_nx;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, sdata_q, ldata_q;
  logic [4:0]  rd_q;
  logic        st_q, err_q;
  logic [7:0]  cnt;
  logic [3:0]  be;
  logic [31:0] wdata, ldata;
  logic        bad, timeout;
  assign bad     = illegal(is_load_i, is_store_i, funct3_i, addr_i[1:0]);
  assign timeout = cnt == 8'(TIMEOUT_CYCLES - 1);
  lsu_align u_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (sdata_q),
    .rdata      (mem_rdata_i),
    .be         (be),
    .wdata      (wdata),
    .load_data  (ldata)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = req_valid_i ? (bad ? DONE : REQ) : IDLE;
      REQ:  state_nx = mem_req_ready_i ? (st_q ? DONE : RSP) : REQ;
      RSP:  state_nx = (mem_rsp_valid_i || timeout) ? DONE : RSP;
      DONE: state_nx = IDLE;
    endcase
  end
  always_comb begin
    stall_o         = state == IDLE ? req_valid_i : state != DONE;
    mem_req_valid_o = state == REQ;
    mem_addr_o      = mem_req_valid_o ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_we_o        = mem_req_valid_o && st_q;
    mem_be_o        = mem_req_valid_o ? be : 4'd0;
    mem_wdata_o     = mem_we_o ? wdata : 32'd0;
    wr_en_o         = state == DONE && !st_q && !err_q && rd_q != 5'd0;
    rd_addr_o       = wr_en_o ? rd_q : 5'd0;
    wr_data_o       = wr_en_o ? ldata_q : 32'd0;
    err_o           = state == DONE && err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      sdata_q <= 32'd0;
      ldata_q <= 32'd0;
      rd_q    <= 5'd0;
      st_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= 8'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (req_valid_i) begin
          f3_q    <= funct3_i;
          addr_q  <= addr_i;
          sdata_q <= store_data_i;
          rd_q    <= rd_addr_i;
          st_q    <= is_store_i;
          err_q   <= bad;
        end
        REQ: cnt <= 8'd0;
        RSP: if (mem_rsp_valid_i) ldata_q <= ldata;
             else begin
               cnt   <= cnt + 8'd1;
               err_q <= timeout;
             end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: randomized transactions checked each cycle against a transaction-level model of the LSU
module tb_lsu_unit;
  localparam int T = 4;
  logic        clk = 1'b0, reset;
  logic        req_valid_i, is_load_i, is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o, mem_req_valid_o, mem_req_ready_i, mem_we_o, mem_rsp_valid_i, wr_en_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, wr_data_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  rd_addr_o;

  always #5 clk = ~clk;

  lsu_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i), .rd_addr_i(rd_addr_i),
    .stall_o(stall_o), .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i), .rd_addr_o(rd_addr_o),
    .wr_en_o(wr_en_o), .wr_data_o(wr_data_o), .err_o(err_o)
  );

  int vecs = 0, errs = 0;
  logic chk_en = 1'b0;
  logic        e_stall, e_mrv, e_we, e_wr, e_err;
  logic [31:0] e_addr, e_wdata, e_wdat;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;
  int          cyc_i, done_at, mrv_cnt;
  logic        wr_seen, s_wr, s_err;
  logic [31:0] s_wdat, r_wdata, r_addr;
  logic [4:0]  s_rd;
  logic [3:0]  r_be;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("stall_o", 32'(stall_o), 32'(e_stall));
    chk("mem_req_valid_o", 32'(mem_req_valid_o), 32'(e_mrv));
    chk("mem_addr_o", mem_addr_o, e_addr);
    chk("mem_we_o", 32'(mem_we_o), 32'(e_we));
    chk("mem_be_o", 32'(mem_be_o), 32'(e_be));
    chk("mem_wdata_o", mem_wdata_o, e_wdata);
    chk("wr_en_o", 32'(wr_en_o), 32'(e_wr));
    chk("rd_addr_o", 32'(rd_addr_o), 32'(e_rd));
    chk("wr_data_o", wr_data_o, e_wdat);
    chk("err_o", 32'(err_o), 32'(e_err));
  end

  function automatic logic m_illegal(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (ld && st) return 1'b1;
    if (st) return f3 > 3'd2 || (f3 == 3'd2 && a % 4 != 0) || (f3 == 3'd1 && a % 2 != 0);
    return f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (f3 == 3'd2 && a % 4 != 0) ||
           ((f3 == 3'd1 || f3 == 3'd5) && a % 2 != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int w = f3 % 4;
    if (w == 0) return 4'(1 << (a % 4));
    if (w == 1) return 4'(3 << (a % 4));
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3 == 3'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rw);
    int k = int'(a % 4);
    int v;
    case (f3)
      3'd0: begin v = int'((rw >> (8 * k)) & 32'hFF); return 32'(v - 2 * (v & 128)); end
      3'd4: return (rw >> (8 * k)) & 32'hFF;
      3'd1: begin v = int'((rw >> (16 * (k / 2))) & 32'hFFFF); return 32'(v - 2 * (v & 32768)); end
      3'd5: return (rw >> (16 * (k / 2))) & 32'hFFFF;
      default: return rw;
    endcase
  endfunction

  task automatic exp_zero();
    e_stall = 0; e_mrv = 0; e_addr = 0; e_we = 0; e_be = 0; e_wdata = 0; e_wr = 0; e_rd = 0; e_wdat = 0; e_err = 0;
  endtask

  task automatic noise();
    mem_rsp_valid_i = 1'($urandom);
    mem_rdata_i     = $urandom;
    mem_req_ready_i = 1'($urandom);
  endtask

  task automatic scramble();
    is_load_i = 1'($urandom); is_store_i = 1'($urandom); funct3_i = 3'($urandom);
    addr_i = $urandom; store_data_i = $urandom; rd_addr_i = 5'($urandom);
  endtask

  task automatic step();
    @(negedge clk);
    cyc_i++;
    if (!stall_o && done_at == 0) done_at = cyc_i;
    if (mem_req_valid_o) begin mrv_cnt++; r_be = mem_be_o; r_wdata = mem_wdata_o; r_addr = mem_addr_o; end
    if (wr_en_o) wr_seen = 1'b1;
    s_wr = wr_en_o; s_rd = rd_addr_o; s_wdat = wr_data_o; s_err = err_o;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid_i = 0; noise(); exp_zero(); step();
  endtask

  task automatic mark();
    cyc_i = 0; done_at = 0; mrv_cnt = 0; wr_seen = 0;
  endtask

  task automatic do_txn(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rw, input int rdly, input int pdly);
    logic bad = m_illegal(ld, st, f3, a);
    logic to;
    req_valid_i = 1; is_load_i = ld; is_store_i = st; funct3_i = f3; addr_i = a; store_data_i = sd; rd_addr_i = rd;
    noise(); exp_zero(); e_stall = 1; step();
    scramble();
    if (!bad) begin
      for (int i = 0; i <= rdly; i++) begin
        noise(); mem_req_ready_i = (i == rdly);
        exp_zero(); e_stall = 1; e_mrv = 1; e_addr = a & 32'hFFFF_FFFC; e_we = st; e_be = m_be(f3, a);
        e_wdata = st ? m_wdata(f3, sd) : 32'd0;
        step();
      end
      if (!st) for (int i = 0; i < (pdly < T ? pdly + 1 : T); i++) begin
        noise(); mem_rsp_valid_i = (i == pdly); if (i == pdly) mem_rdata_i = rw;
        exp_zero(); e_stall = 1; step();
      end
    end
    noise(); req_valid_i = 1'($urandom); exp_zero();
    to = !bad && !st && pdly >= T;
    e_err = bad || to; e_wr = !e_err && !st && rd != 0;
    e_rd = e_wr ? rd : 5'd0; e_wdat = e_wr ? m_load(f3, a, rw) : 32'd0;
    step();
    req_valid_i = 0; exp_zero();
  endtask

  initial begin
    reset = 1; req_valid_i = 0; scramble(); noise(); exp_zero();
    @(posedge clk); #1;
    chk_en = 1; mark();
    step(); step();
    chk("reset_no_stall", 32'(done_at), 32'd1);
    reset = 0;
    idle();
    mark(); do_txn(1, 0, 3'd0, 32'h1003, 32'h0, 5'd5, 32'h80FF_1234, 0, 0);
    chk("lb_done_cycle", 32'(done_at), 32'd4);
    chk("lb_wr_en", 32'(s_wr), 32'd1);
    chk("lb_rd", 32'(s_rd), 32'd5);
    chk("lb_data", s_wdat, 32'hFFFF_FF80);
    mark(); do_txn(1, 0, 3'd4, 32'h1003, 32'h0, 5'd5, 32'h80FF_1234, 0, 0);
    chk("lbu_data", s_wdat, 32'h0000_0080);
    mark(); do_txn(0, 1, 3'd1, 32'h2002, 32'h0000_BEEF, 5'd7, 32'h0, 3, 0);
    chk("sh_be", 32'(r_be), 32'hC);
    chk("sh_wdata", r_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", r_addr, 32'h2000);
    chk("sh_req_cycles", 32'(mrv_cnt), 32'd4);
    chk("sh_done_cycle", 32'(done_at), 32'd6);
    chk("sh_no_write", 32'(wr_seen), 32'd0);
    idle();
    mark(); do_txn(1, 0, 3'd2, 32'h3001, 32'h0, 5'd3, 32'h0, 0, 0);
    chk("misalign_done_cycle", 32'(done_at), 32'd2);
    chk("misalign_err", 32'(s_err), 32'd1);
    chk("misalign_no_req", 32'(mrv_cnt), 32'd0);
    chk("misalign_no_write", 32'(wr_seen), 32'd0);
    mark(); do_txn(1, 0, 3'd2, 32'h4000, 32'h0, 5'd0, 32'h1234_5678, 0, 1);
    chk("rd0_req_cycles", 32'(mrv_cnt), 32'd1);
    chk("rd0_no_write", 32'(wr_seen), 32'd0);
    chk("rd0_done_cycle", 32'(done_at), 32'd5);
    mark(); do_txn(1, 0, 3'd2, 32'h5000, 32'h0, 5'd9, 32'h0, 0, 10);
    chk("timeout_done_cycle", 32'(done_at), 32'd7);
    chk("timeout_err", 32'(s_err), 32'd1);
    idle();
    mark();
    req_valid_i = 1; is_load_i = 1; is_store_i = 0; funct3_i = 3'd2; addr_i = 32'h6000; rd_addr_i = 5'd4;
    noise(); exp_zero(); e_stall = 1; step();
    noise(); mem_req_ready_i = 1; mem_rsp_valid_i = 0;
    e_mrv = 1; e_addr = 32'h6000; e_be = 4'hF; step();
    noise(); mem_rsp_valid_i = 0; exp_zero(); e_stall = 1; reset = 1; step();
    reset = 0; req_valid_i = 0; mem_rsp_valid_i = 1; mem_rdata_i = 32'hDEAD_BEEF; exp_zero(); step();
    idle();
    chk("reset_rsp_no_write", 32'(wr_seen), 32'd0);
    for (int n = 0; n < 300; n++) begin
      int r = $urandom_range(0, 9);
      logic st = r < 4, ld = r >= 4;
      logic [2:0] f3 = 3'($urandom);
      logic [31:0] a = $urandom;
      if (r == 9) st = 1;
      if ($urandom_range(0, 1)) a[1:0] = f3[1:0] == 2'd2 ? 2'd0 : f3[1:0] == 2'd1 ? {a[1], 1'b0} : a[1:0];
      do_txn(ld, st, f3, a, $urandom, 5'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 5));
      for (int g = $urandom_range(0, 2); g > 0; g--) idle();
    end
    idle();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
